// File: rtl/ae_rx_pkg.sv
// Shared types and constants for the AE spectrogram serial receiver.
package ae_rx_pkg;

  localparam int unsigned AE_TIME_W      = 16;
  localparam int unsigned AE_CH_W        = 7;
  localparam int unsigned AE_DEPTH       = 4;
  localparam int unsigned MAX_IDLE_BEATS = 3;

  typedef enum logic [1:0] {
    IDLE,
    TIME,
    WAIT_CH,
    CHAN
  } rx_state_t;

  // 'time' is a reserved word, so the timestamp field is time_stamp.
  typedef struct packed {
    logic [AE_TIME_W-1:0] time_stamp;
    logic [AE_CH_W-1:0]   ch1;
    logic [AE_CH_W-1:0]   ch2;
  } ae_record_t;

endpackage

// File: rtl/ae_rx_fifo.sv
// Synchronous record FIFO; read data is combinational from the head slot and
// forced to zero while empty.
module ae_rx_fifo
  import ae_rx_pkg::*;
#(
  parameter int unsigned DEPTH = AE_DEPTH,
  parameter type         rec_t = ae_record_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers/count define
  // validity and the empty mask below yields zero data after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? rec_t'('0) : mem_q[rd_ptr_q];

endmodule

// File: rtl/ae_serial_frame_rx.sv
// 2-lane AE spectrogram frame receiver: framing FSM, shift registers, record FIFO.
// Optional statistics counters are built when AE_RX_STATS_EN is defined.
module ae_serial_frame_rx
  import ae_rx_pkg::*;
#(
  parameter int unsigned TIME_W = AE_TIME_W,
  parameter int unsigned CH_W   = AE_CH_W,
  parameter int unsigned DEPTH  = AE_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [1:0]        serial_in,
  input  logic              sl_time,
  input  logic              sl_ch,
  input  logic              sending_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] out_time,
  output logic [CH_W-1:0]   out_ch1,
  output logic [CH_W-1:0]   out_ch2,
  output logic              frame_err,
  output logic              fifo_full
`ifdef AE_RX_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned TIME_BEATS = TIME_W / 2;
  localparam int unsigned MAX_BEATS  = (TIME_BEATS > CH_W) ? TIME_BEATS : CH_W;
  localparam int unsigned CNT_W      = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] TIME_LAST  = CNT_W'(TIME_BEATS);
  localparam logic [CNT_W-1:0] CH_LAST    = CNT_W'(CH_W);
  localparam logic [1:0]       IDLE_LIMIT = 2'(MAX_IDLE_BEATS);

  typedef struct packed {
    logic [TIME_W-1:0] time_stamp;
    logic [CH_W-1:0]   ch1;
    logic [CH_W-1:0]   ch2;
  } rec_t;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d, beat_inc;
  logic [1:0]        idle_q, idle_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [CH_W-1:0]   ch1_q, ch1_d, ch2_q, ch2_d;
  logic              err_d, push, pop, drop, fifo_empty, frame_err_q;
  rec_t              push_rec, head_rec;

  assign beat_inc = beat_q + CNT_W'(1);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    time_d  = time_q;
    ch1_d   = ch1_q;
    ch2_d   = ch2_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          if (sl_time && !sl_ch && sending_data) begin
            time_d  = TIME_W'(serial_in);
            beat_d  = CNT_W'(1);
            idle_d  = '0;
            state_d = (TIME_LAST == CNT_W'(1)) ? WAIT_CH : TIME;
          end
        end
        TIME: begin
          if (!sending_data || !sl_time || sl_ch) begin
            err_d = 1'b1;
          end else begin
            time_d = TIME_W'({time_q, serial_in});
            beat_d = beat_inc;
            if (beat_inc == TIME_LAST) state_d = WAIT_CH;
          end
        end
        WAIT_CH: begin
          // sl_time still high here covers both a held marker and a new one.
          if (!sending_data || sl_time) begin
            err_d = 1'b1;
          end else if (sl_ch) begin
            ch1_d  = CH_W'(serial_in[0]);
            ch2_d  = CH_W'(serial_in[1]);
            beat_d = CNT_W'(1);
            if (CH_LAST == CNT_W'(1)) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = CHAN;
            end
          end else if (idle_q == IDLE_LIMIT) begin
            err_d = 1'b1;
          end else begin
            idle_d = idle_q + 2'd1;
          end
        end
        CHAN: begin
          if (!sending_data || sl_time || !sl_ch) begin
            err_d = 1'b1;
          end else begin
            ch1_d  = CH_W'({ch1_q, serial_in[0]});
            ch2_d  = CH_W'({ch2_q, serial_in[1]});
            beat_d = beat_inc;
            if (beat_inc == CH_LAST) begin
              push    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (err_d) state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      idle_q      <= '0;
      time_q      <= '0;
      ch1_q       <= '0;
      ch2_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      idle_q      <= idle_d;
      time_q      <= time_d;
      ch1_q       <= ch1_d;
      ch2_q       <= ch2_d;
      frame_err_q <= err_d || drop;
    end
  end

  assign push_rec = '{time_stamp: time_q, ch1: ch1_d, ch2: ch2_d};
  assign pop      = out_ready && !fifo_empty;
  assign drop     = push && fifo_full && !pop;

  ae_rx_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .pop       (out_ready),
    .head_data (head_rec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_time  = head_rec.time_stamp;
  assign out_ch1   = head_rec.ch1;
  assign out_ch2   = head_rec.ch2;
  assign frame_err = frame_err_q;

`ifdef AE_RX_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (push && !drop) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((err_d || drop) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ae_serial_frame_rx.sv
// Scoreboard bench for ae_serial_frame_rx: frame-level driver with fault injection,
// expected records queued at issue time, independent monitor pops and compares.
module tb_ae_serial_frame_rx;

  localparam int TIME_W = 16;
  localparam int CH_W   = 7;
  localparam int DEPTH  = 4;
  localparam int TBEATS = TIME_W / 2;
  localparam int MAX_IDLE = 3;

  localparam int F_NONE  = 0;
  localparam int F_BOTH  = 1;
  localparam int F_TDROP = 2;
  localparam int F_SD_T  = 3;
  localparam int F_HOLD  = 4;
  localparam int F_CDROP = 5;
  localparam int F_TRISE = 6;
  localparam int F_SD_C  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en, sl_time, sl_ch, sending_data, out_ready;
  logic [1:0]        serial_in;
  logic              out_valid, frame_err, fifo_full;
  logic [TIME_W-1:0] out_time;
  logic [CH_W-1:0]   out_ch1, out_ch2;
`ifdef AE_RX_STATS_EN
  logic [15:0]       frame_cnt;
  logic [7:0]        err_cnt;
`endif

  typedef struct {
    logic [TIME_W-1:0] t;
    logic [CH_W-1:0]   c1;
    logic [CH_W-1:0]   c2;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  int tests_run = 0, tests_failed = 0;
  int err_exp = 0, err_seen = 0, frames_ok = 0, occ = 0;
  int gap_n = 0, ready_mode = 0;
  bit chk_lat = 1'b0;

  always #5 clk = ~clk;

  ae_serial_frame_rx #(
    .TIME_W (TIME_W),
    .CH_W   (CH_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_en    (sample_en),
    .serial_in    (serial_in),
    .sl_time      (sl_time),
    .sl_ch        (sl_ch),
    .sending_data (sending_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_time     (out_time),
    .out_ch1      (out_ch1),
    .out_ch2      (out_ch2),
    .frame_err    (frame_err),
    .fifo_full    (fifo_full)
`ifdef AE_RX_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .err_cnt      (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; non-sampled inputs carry random garbage.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    sample_en    = 1'b0;
    serial_in    = 2'($urandom);
    sl_time      = 1'($urandom);
    sl_ch        = 1'($urandom);
    sending_data = 1'($urandom);
    out_ready    = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
  endtask

  task automatic beat(input logic t, input logic c, input logic sd, input logic [1:0] ln);
    sample_en    = 1'b1;
    sl_time      = t;
    sl_ch        = c;
    sending_data = sd;
    serial_in    = ln;
    next_cycle();
    repeat (gap_n) next_cycle();
  endtask

  // Sends one frame; stops right after an injected error beat.
  task automatic send_frame(input logic [TIME_W-1:0] t, input logic [CH_W-1:0] c1,
                            input logic [CH_W-1:0] c2, input int idle_n,
                            input int fault, input int fb, input bit ready_last);
    logic [1:0] ln;
    exp_rec_t   r;
    for (int i = 0; i < TBEATS; i++) begin
      ln = {t[TIME_W-1-2*i], t[TIME_W-2-2*i]};
      if (i == fb && fault == F_BOTH)  begin beat(1'b1, 1'b1, 1'b1, ln); err_exp++; return; end
      if (i == fb && fault == F_TDROP) begin beat(1'b0, 1'b0, 1'b1, ln); err_exp++; return; end
      if (i == fb && fault == F_SD_T)  begin beat(1'b1, 1'b0, 1'b0, ln); err_exp++; return; end
      beat(1'b1, 1'b0, 1'b1, ln);
    end
    if (fault == F_HOLD) begin beat(1'b1, 1'b0, 1'b1, 2'b00); err_exp++; return; end
    for (int i = 0; i < idle_n; i++) begin
      beat(1'b0, 1'b0, 1'b1, 2'($urandom));
      if (i == MAX_IDLE) begin err_exp++; return; end
    end
    for (int j = 0; j < CH_W; j++) begin
      ln = {c2[CH_W-1-j], c1[CH_W-1-j]};
      if (j == fb && fault == F_CDROP) begin beat(1'b0, 1'b0, 1'b1, ln); err_exp++; return; end
      if (j == fb && fault == F_TRISE) begin beat(1'b1, 1'b0, 1'b1, ln); err_exp++; return; end
      if (j == fb && fault == F_SD_C)  begin beat(1'b0, 1'b1, 1'b0, ln); err_exp++; return; end
      if (j == CH_W - 1) begin
        if (ready_last) out_ready = 1'b1;
        if (chk_lat) check("valid_before_last_beat", 64'(out_valid), 0);
        if (occ < DEPTH || out_ready) begin
          r.t = t; r.c1 = c1; r.c2 = c2;
          exp_q.push_back(r);
          occ++;
          frames_ok++;
        end else begin
          err_exp++;
        end
      end
      beat(1'b0, 1'b1, 1'b1, ln);
    end
  endtask

  task automatic clean_frame(input int idle_n);
    send_frame(16'($urandom), 7'($urandom), 7'($urandom), idle_n, F_NONE, 0, 1'b0);
  endtask

  task automatic settle(input string name);
    repeat (4) next_cycle();
    check(name, 64'(err_seen), 64'(err_exp));
  endtask

  task automatic drain(input string name);
    ready_mode = 1;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    next_cycle();
    check(name, 64'(exp_q.size()), 0);
    check({name, "_valid_low"}, 64'(out_valid), 0);
    ready_mode = 0;
  endtask

  task automatic check_stats(input string name);
`ifdef AE_RX_STATS_EN
    check({name, "_frame_cnt"}, 64'(frame_cnt), 64'(frames_ok));
    check({name, "_err_cnt"}, 64'(err_cnt), 64'((err_exp > 255) ? 255 : err_exp));
`else
    check({name, "_err_seen"}, 64'(err_seen), 64'(err_exp));
`endif
  endtask

  // Monitor: counts error pulses and scores every accepted record.
  initial begin
    exp_rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) err_seen++;
        if (out_valid && out_ready) begin
          check("record_expected", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            occ--;
            check("rec_time", 64'(out_time), 64'(r.t));
            check("rec_ch1", 64'(out_ch1), 64'(r.c1));
            check("rec_ch2", 64'(out_ch2), 64'(r.c2));
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fault, fb, idle_n;
    rst_n = 1'b0; sample_en = 1'b0; serial_in = '0; sl_time = 1'b0; sl_ch = 1'b0;
    sending_data = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 0);
    check("reset_full", 64'(fifo_full), 0);
    check("reset_err", 64'(frame_err), 0);
    check("reset_time", 64'(out_time), 0);
    rst_n = 1'b1;
    check_stats("reset");

    // 1: single frame, latency of out_valid
    ready_mode = 0; gap_n = 0; chk_lat = 1'b1;
    send_frame(16'hA5C3, 7'h55, 7'h2A, 0, F_NONE, 0, 1'b0);
    chk_lat = 1'b0;
    check("s1_valid_after_last", 64'(out_valid), 1);
    check("s1_time", 64'(out_time), 64'h A5C3);
    check("s1_ch1", 64'(out_ch1), 64'h55);
    check("s1_ch2", 64'(out_ch2), 64'h2A);
    drain("s1_drain");
    settle("s1_err");

    // 2: sample_en every 3rd cycle, idle beats 2 and 3 fine, 4 fails
    gap_n = 2;
    clean_frame(2);
    clean_frame(3);
    send_frame(16'h1234, 7'h11, 7'h22, 4, F_NONE, 0, 1'b0);
    settle("s2_err");
    drain("s2_drain");
    gap_n = 0;

    // 3: sl_ch drops after 4 CHAN beats, then a clean frame
    send_frame(16'hBEEF, 7'h7F, 7'h00, 1, F_CDROP, 4, 1'b0);
    settle("s3_err");
    clean_frame(0);
    drain("s3_drain");

    // 4: five frames while blocked; fifth is dropped
    for (int n = 0; n < 5; n++) begin
      clean_frame(n % 3);
      if (n == 2) check("s4_not_full_at_3", 64'(fifo_full), 0);
      if (n == 3) check("s4_full_at_4", 64'(fifo_full), 1);
    end
    check("s4_full_after_5", 64'(fifo_full), 1);
    settle("s4_err");
    check_stats("s1to4");
    drain("s4_drain");

    // 5: full FIFO with pop on the last beat of a new frame
    for (int n = 0; n < DEPTH; n++) clean_frame(0);
    check("s5_full", 64'(fifo_full), 1);
    send_frame(16'($urandom), 7'($urandom), 7'($urandom), 1, F_NONE, 0, 1'b1);
    check("s5_still_full", 64'(fifo_full), 1);
    settle("s5_err");
    drain("s5_drain");

    // Random frames, gaps, idle counts, faults and back-pressure
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      gap_n  = $urandom_range(0, 3);
      idle_n = ($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3);
      fault  = $urandom_range(0, 11);
      if (fault > F_SD_C) fault = F_NONE;
      case (fault)
        F_BOTH, F_TDROP, F_SD_T: fb = $urandom_range(1, TBEATS - 1);
        F_CDROP:                 fb = $urandom_range(1, CH_W - 1);
        default:                 fb = $urandom_range(0, CH_W - 1);
      endcase
      send_frame(16'($urandom), 7'($urandom), 7'($urandom), idle_n, fault, fb, 1'b0);
    end
    gap_n = 0;
    settle("rand_err");
    check_stats("rand");
    drain("rand_drain");

    // 6: reset mid-TIME with a record pending
    ready_mode = 0;
    clean_frame(0);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b1, 2'($urandom));
    rst_n = 1'b0;
    exp_q.delete();
    occ = 0; frames_ok = 0; err_exp = 0; err_seen = 0;
    next_cycle();
    rst_n = 1'b1;
    check("s6_valid", 64'(out_valid), 0);
    check("s6_full", 64'(fifo_full), 0);
    check("s6_err", 64'(frame_err), 0);
    check("s6_data", 64'({out_time, out_ch1, out_ch2}), 0);
    check_stats("s6_reset");
    settle("s6_no_err");
    clean_frame(1);
    settle("s6_err_after");
    check_stats("s6_after");
    drain("s6_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
